// File: rtl/uart_pkg.sv
// Shared UART definitions: frame widths, error flag bit positions and the
// layout of one buffered receive entry. Also used by the RX and TX units.
package uart_pkg;

    localparam int UART_DATA_W  = 8;
    localparam int UART_ERR_W   = 3;
    localparam int UART_ENTRY_W = UART_DATA_W + UART_ERR_W;

    // Bit positions inside the receiver error flag vector
    localparam int ERR_PARITY = 0;
    localparam int ERR_START  = 1;
    localparam int ERR_STOP   = 2;

    // One buffered frame, error flags in the upper bits
    typedef struct packed {
        logic [UART_ERR_W-1:0]  err;
        logic [UART_DATA_W-1:0] data;
    } uart_entry_t;

    // A frame is errored when any of its error flags is set
    function automatic logic frame_has_error(input logic [UART_ERR_W-1:0] err);
        return |err;
    endfunction

endpackage : uart_pkg

// File: rtl/uart_fifo_ram.sv
// Storage array for the receive FIFO: synchronous write, asynchronous read.
// Contents are deliberately not reset; the pointers and fill level decide
// which locations are meaningful.
module uart_fifo_ram
    import uart_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int WIDTH  = UART_ENTRY_W
) (
    input  logic              clock,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WIDTH-1:0]  rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Write port: one entry per enabled clock
    always_ff @(posedge clock) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read port is combinational so the head entry falls through immediately
    assign rdata_o = mem_q[raddr_i];

endmodule : uart_fifo_ram

// File: rtl/uart_rx_fifo.sv
// Receive-side buffer behind the UART receiver. Captures one frame per rising
// edge of the receiver's done flag, stores it in a first-word-fall-through
// FIFO, and keeps sticky overflow status plus a saturating errored-frame count.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 8
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   rx_done_flag,
    input  logic [UART_DATA_W-1:0] rx_data,
    input  logic [UART_ERR_W-1:0]  rx_error_flag,
    input  logic                   drop_errored,
    input  logic                   clear_status,
    input  logic                   rd_ready,
    output logic                   rd_valid,
    output logic [UART_DATA_W-1:0] rd_data,
    output logic [UART_ERR_W-1:0]  rd_error,
    output logic [ADDR_W:0]        fill_level,
    output logic                   full,
    output logic                   overflow_flag,
    output logic [CNT_W-1:0]       err_count
);

    localparam logic [ADDR_W:0]   FILL_MAX = (ADDR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

    logic              done_q;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   fill_q, fill_d;
    logic              ovf_q, ovf_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              cap;
    logic              frame_err;
    logic              wr;
    logic              rd;
    logic              wr_ok;
    logic              ovf_set;
    logic [CNT_W-1:0]  cnt_base;

    uart_entry_t       wr_entry;
    uart_entry_t       rd_entry;

    // Edge detect: done_q starts high so a flag already asserted at reset
    // release is ignored until it drops and rises again.
    assign cap       = rx_done_flag & ~done_q;
    assign frame_err = frame_has_error(rx_error_flag);
    assign wr        = cap & ~(drop_errored & frame_err);

    assign rd_valid  = (fill_q != '0);
    assign full      = (fill_q == FILL_MAX);
    assign rd        = rd_valid & rd_ready;

    // A full FIFO still accepts a write when the head is popped the same cycle
    assign wr_ok     = wr & (~full | rd);
    assign ovf_set   = wr & full & ~rd;

    assign wr_entry.err  = rx_error_flag;
    assign wr_entry.data = rx_data;

    uart_fifo_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .WIDTH  (UART_ENTRY_W)
    ) u_ram (
        .clock   (clock),
        .we_i    (wr_ok),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_entry),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_entry)
    );

    // Next-state for pointers, fill level and status; set/increment beats clear
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        ovf_d    = ovf_q;
        cnt_d    = cnt_q;
        cnt_base = cnt_q;

        // Pointers are ADDR_W bits wide, so +1 wraps DEPTH-1 -> 0 naturally
        if (wr_ok) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
        if (rd) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end

        case ({wr_ok, rd})
            2'b10:   fill_d = fill_q + (ADDR_W + 1)'(1);
            2'b01:   fill_d = fill_q - (ADDR_W + 1)'(1);
            default: fill_d = fill_q;
        endcase

        if (clear_status) begin
            ovf_d    = 1'b0;
            cnt_base = '0;
        end
        if (ovf_set) begin
            ovf_d = 1'b1;
        end

        // Errored frames are counted even when they are dropped
        cnt_d = cnt_base;
        if (cap && frame_err && (cnt_base != CNT_MAX)) begin
            cnt_d = cnt_base + CNT_W'(1);
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            done_q   <= 1'b1;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
            ovf_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            done_q   <= rx_done_flag;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
            ovf_q    <= ovf_d;
            cnt_q    <= cnt_d;
        end
    end

    // Stale RAM contents are hidden whenever the FIFO is empty
    assign rd_data       = rd_valid ? rd_entry.data : '0;
    assign rd_error      = rd_valid ? rd_entry.err  : '0;
    assign fill_level    = fill_q;
    assign overflow_flag = ovf_q;
    assign err_count     = cnt_q;

endmodule : uart_rx_fifo
